// File: rtl/clock_divider_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clock_divider_pkg;

    // Divisor every channel starts from after reset.
    localparam int DIV_DEFAULT = 4;

    // Divisors below this value disable a channel (clk_o and tick_o held low).
    localparam int DIS_THRESH = 2;

    // Number of high cycles in a period of length a (the odd cycle goes high).
    function automatic int unsigned ceil_half(input int unsigned a);
        return (a + 32'd1) / 32'd2;
    endfunction

endpackage

// File: rtl/clock_divider_multi_if.sv
// Divisor-write handshake between a configuring master and the divider.
interface clock_divider_multi_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [WIDTH-1:0] cfg_div;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        output cfg_ready
    );

endinterface

// File: rtl/clock_divider_ch.sv
// One divider channel: active/shadow divisor, period counter, registered clock and tick.
// A new divisor waits in the shadow register and only becomes active at a period
// boundary (wrap), on the next edge when the channel is disabled, or on sync.
module clock_divider_ch
    import clock_divider_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_div,
    input  logic             sync,
    output logic             clk_o,
    output logic             tick_o,
    output logic             pending
);

    logic [WIDTH-1:0] act;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] next_act;
    logic             enabled;
    logic             wrap;
    logic             apply;

    // Period bookkeeping and the decision whether this edge is an apply point.
    always_comb begin
        enabled  = (act >= WIDTH'(DIS_THRESH));
        wrap     = enabled && (cnt == (act - WIDTH'(1)));
        apply    = sync || (pending && (wrap || !enabled));
        next_act = (apply && pending) ? shadow : act;
        cnt_next = wrap ? '0 : (cnt + WIDTH'(1));
        half     = WIDTH'(ceil_half(32'(act)));
    end

    // Channel state; outputs come straight from flops so they cannot glitch.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act     <= WIDTH'(DEFAULT_DIV);
            shadow  <= WIDTH'(DEFAULT_DIV);
            pending <= 1'b0;
            cnt     <= '0;
            clk_o   <= 1'b0;
            tick_o  <= 1'b0;
        end else begin
            if (apply) begin
                // Restart at phase 0; the first cycle of an enabled period is high and ticks.
                act     <= next_act;
                pending <= 1'b0;
                cnt     <= '0;
                clk_o   <= (next_act >= WIDTH'(DIS_THRESH));
                tick_o  <= (next_act >= WIDTH'(DIS_THRESH));
            end else if (enabled) begin
                cnt    <= cnt_next;
                clk_o  <= (cnt_next < half);
                tick_o <= (cnt_next == '0);
            end else begin
                cnt    <= '0;
                clk_o  <= 1'b0;
                tick_o <= 1'b0;
            end
            // A write landing on an apply edge only loads the shadow; it waits for the next one.
            if (wr_en) begin
                shadow  <= wr_div;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_divider_multi.sv
// N_CH independent runtime-programmable clock dividers sharing one system clock.
// Writes to a channel are refused while that channel still holds an unapplied divisor;
// channel numbers beyond N_CH are accepted and dropped.
module clock_divider_multi
    import clock_divider_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = DIV_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rstn,
    clock_divider_multi_if.slave  cfg,
    input  logic                  sync_i,
    output logic [N_CH-1:0]       clk_o,
    output logic [N_CH-1:0]       tick_o,
    output logic [N_CH-1:0]       pending_o
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic            ready;
    logic [N_CH-1:0] wr_en;

    // Channel decode: ready reflects the addressed channel, out-of-range reads as ready.
    always_comb begin
        ready = 1'b1;
        wr_en = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg.cfg_ch == CH_W'(i)) begin
                ready = !pending_o[i];
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            wr_en[i] = cfg.cfg_valid && ready && (cfg.cfg_ch == CH_W'(i));
        end
    end

    assign cfg.cfg_ready = ready;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clock_divider_ch #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .rstn    (rstn),
            .wr_en   (wr_en[g]),
            .wr_div  (cfg.cfg_div),
            .sync    (sync_i),
            .clk_o   (clk_o[g]),
            .tick_o  (tick_o[g]),
            .pending (pending_o[g])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed scoreboard bench: each stimulus row pushes the hand-computed outputs expected
// after the next rising edge; a monitor pops and compares shortly after that edge.
// A second, 3-channel instance receives writes to channel 3 (out of range) and must
// behave exactly like untouched default channels.
module tb_clock_divider_multi;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       sync_i;
    logic [3:0] clk_o, tick_o, pending_o;
    logic [2:0] clk3_o, tick3_o, pending3_o;

    clock_divider_multi_if #(.N_CH(4), .WIDTH(8)) cfg ();
    clock_divider_multi_if #(.N_CH(3), .WIDTH(8)) cfg3 ();

    clock_divider_multi #(.N_CH(4), .WIDTH(8), .DEFAULT_DIV(4)) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .cfg       (cfg),
        .sync_i    (sync_i),
        .clk_o     (clk_o),
        .tick_o    (tick_o),
        .pending_o (pending_o)
    );

    clock_divider_multi #(.N_CH(3), .WIDTH(8), .DEFAULT_DIV(4)) u_dut3 (
        .clk       (clk),
        .rstn      (rstn),
        .cfg       (cfg3),
        .sync_i    (sync_i),
        .clk_o     (clk3_o),
        .tick_o    (tick3_o),
        .pending_o (pending3_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [3:0] c;
        logic [3:0] t;
        logic [3:0] p;
        logic       r;
        logic       chk3;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   row_idx = 0;
    bit   chk3 = 1'b0;

    function automatic void cmp(input string name, input int idx,
                                input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
        end
    endfunction

    // Drive one cycle of stimulus at the falling edge and queue the expected response.
    task automatic row(input bit rst, input bit v, input bit [1:0] ch, input bit [7:0] div,
                       input bit sy, input bit [3:0] ec, input bit [3:0] et,
                       input bit [3:0] ep, input bit er);
        exp_t e;
        @(negedge clk);
        if (!rst && rstn) begin
            rstn = 1'b0;
            #1;
            cmp("async_rst", row_idx, 32'({clk_o, tick_o, pending_o}), 32'h0);
        end
        rstn           = rst;
        cfg.cfg_valid  = v;
        cfg.cfg_ch     = ch;
        cfg.cfg_div    = div;
        sync_i         = sy;
        cfg3.cfg_valid = chk3;
        cfg3.cfg_ch    = 2'd3;
        cfg3.cfg_div   = 8'd2;
        e.idx  = row_idx;
        e.c    = ec;
        e.t    = et;
        e.p    = ep;
        e.r    = er;
        e.chk3 = chk3;
        exp_q.push_back(e);
        row_idx++;
    endtask

    // Monitor: compare every queued expectation 2 ns after the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("clk_o",     e.idx, 32'(clk_o),         32'(e.c));
                cmp("tick_o",    e.idx, 32'(tick_o),        32'(e.t));
                cmp("pending_o", e.idx, 32'(pending_o),     32'(e.p));
                cmp("cfg_ready", e.idx, 32'(cfg.cfg_ready), 32'(e.r));
                if (e.chk3) begin
                    cmp("oor_clk",     e.idx, 32'(clk3_o),         32'(e.c[2:0]));
                    cmp("oor_tick",    e.idx, 32'(tick3_o),        32'(e.t[2:0]));
                    cmp("oor_pending", e.idx, 32'(pending3_o),     32'h0);
                    cmp("oor_ready",   e.idx, 32'(cfg3.cfg_ready), 32'h1);
                end
            end
        end
    end

    initial begin
        cfg.cfg_valid  = 1'b0;
        cfg.cfg_ch     = '0;
        cfg.cfg_div    = '0;
        cfg3.cfg_valid = 1'b0;
        cfg3.cfg_ch    = '0;
        cfg3.cfg_div   = '0;
        sync_i         = 1'b0;

        // Reset, then default divide-by-4 (out-of-range writes hammer the 3-channel DUT).
        chk3 = 1'b1;
        row(0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 1);
        row(1, 0, 0, 0, 0, 4'hF, 4'h0, 4'h0, 1);
        row(1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 1);
        row(1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 1);
        row(1, 0, 0, 0, 0, 4'hF, 4'hF, 4'h0, 1);
        row(1, 0, 0, 0, 0, 4'hF, 4'h0, 4'h0, 1);
        row(1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 1);
        row(1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 1);
        row(1, 0, 0, 0, 0, 4'hF, 4'hF, 4'h0, 1);
        chk3 = 1'b0;

        // ch1 <= 7 mid-period: pending until ch1 wraps, then 4 high / 3 low.
        row(1, 1, 1, 7, 0, 4'hF, 4'h0, 4'h2, 0);
        row(1, 0, 1, 0, 0, 4'h0, 4'h0, 4'h2, 0);
        row(1, 0, 1, 0, 0, 4'h0, 4'h0, 4'h2, 0);
        row(1, 0, 1, 0, 0, 4'hF, 4'hF, 4'h0, 1);
        row(1, 0, 1, 0, 0, 4'hF, 4'h0, 4'h0, 1);
        row(1, 0, 1, 0, 0, 4'h2, 4'h0, 4'h0, 1);
        row(1, 0, 1, 0, 0, 4'h2, 4'h0, 4'h0, 1);
        row(1, 0, 1, 0, 0, 4'hD, 4'hD, 4'h0, 1);
        row(1, 0, 1, 0, 0, 4'hD, 4'h0, 4'h0, 1);
        row(1, 0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 1);
        row(1, 0, 1, 0, 0, 4'h2, 4'h2, 4'h0, 1);
        row(1, 0, 1, 0, 0, 4'hF, 4'hD, 4'h0, 1);

        // ch2 <= 0 disables at its wrap; ch2 <= 3 applies on the very next edge.
        row(1, 1, 2, 0, 0, 4'hF, 4'h0, 4'h4, 0);
        row(1, 0, 2, 0, 0, 4'h2, 4'h0, 4'h4, 0);
        row(1, 0, 2, 0, 0, 4'h0, 4'h0, 4'h4, 0);
        row(1, 0, 2, 0, 0, 4'h9, 4'h9, 4'h0, 1);
        row(1, 0, 2, 0, 0, 4'h9, 4'h0, 4'h0, 1);
        row(1, 1, 2, 3, 0, 4'h2, 4'h2, 4'h4, 0);
        row(1, 0, 2, 0, 0, 4'h6, 4'h4, 4'h0, 1);
        row(1, 0, 2, 0, 0, 4'hF, 4'h9, 4'h0, 1);
        row(1, 0, 2, 0, 0, 4'hB, 4'h0, 4'h0, 1);
        row(1, 0, 2, 0, 0, 4'h4, 4'h4, 4'h0, 1);
        row(1, 0, 2, 0, 0, 4'h4, 4'h0, 4'h0, 1);

        // ch0 <= 5 (on its wrap edge), ch3 <= 6, then sync: every channel restarts together.
        row(1, 1, 0, 5, 0, 4'h9, 4'h9, 4'h1, 0);
        row(1, 1, 3, 6, 0, 4'hF, 4'h6, 4'h9, 0);
        row(1, 0, 3, 0, 1, 4'hF, 4'hF, 4'h0, 1);
        row(1, 0, 3, 0, 0, 4'hF, 4'h0, 4'h0, 1);
        row(1, 0, 3, 0, 0, 4'hB, 4'h0, 4'h0, 1);
        row(1, 0, 3, 0, 0, 4'h6, 4'h4, 4'h0, 1);
        row(1, 0, 3, 0, 0, 4'h4, 4'h0, 4'h0, 1);
        row(1, 0, 3, 0, 0, 4'h1, 4'h1, 4'h0, 1);
        row(1, 0, 3, 0, 0, 4'hD, 4'hC, 4'h0, 1);
        row(1, 0, 3, 0, 0, 4'hF, 4'h2, 4'h0, 1);
        row(1, 0, 3, 0, 0, 4'hA, 4'h0, 4'h0, 1);
        row(1, 0, 3, 0, 0, 4'h6, 4'h4, 4'h0, 1);
        row(1, 0, 3, 0, 0, 4'h7, 4'h1, 4'h0, 1);
        row(1, 0, 3, 0, 0, 4'h1, 4'h0, 4'h0, 1);
        row(1, 0, 3, 0, 0, 4'hD, 4'hC, 4'h0, 1);
        row(1, 0, 3, 0, 0, 4'hC, 4'h0, 4'h0, 1);

        // ch1 <= 2 on ch1's exact wrap edge: divide-by-7 runs one more full period.
        row(1, 1, 1, 2, 0, 4'hA, 4'h2, 4'h2, 0);
        row(1, 0, 1, 0, 0, 4'h7, 4'h5, 4'h2, 0);
        row(1, 0, 1, 0, 0, 4'h7, 4'h0, 4'h2, 0);
        row(1, 0, 1, 0, 0, 4'h3, 4'h0, 4'h2, 0);
        row(1, 0, 1, 0, 0, 4'hC, 4'hC, 4'h2, 0);
        row(1, 0, 1, 0, 0, 4'hC, 4'h0, 4'h2, 0);
        row(1, 0, 1, 0, 0, 4'h9, 4'h1, 4'h2, 0);
        row(1, 0, 1, 0, 0, 4'h7, 4'h6, 4'h0, 1);
        row(1, 0, 1, 0, 0, 4'h5, 4'h0, 4'h0, 1);
        row(1, 0, 1, 0, 0, 4'h2, 4'h2, 4'h0, 1);

        // ch0 <= 3 together with sync: sync restarts all, the write waits for ch0's next wrap.
        row(1, 1, 0, 3, 1, 4'hF, 4'hF, 4'h1, 0);
        row(1, 0, 0, 0, 0, 4'hD, 4'h0, 4'h1, 0);
        row(1, 0, 0, 0, 0, 4'hB, 4'h2, 4'h1, 0);
        row(1, 0, 0, 0, 0, 4'h4, 4'h4, 4'h1, 0);
        row(1, 0, 0, 0, 0, 4'h6, 4'h2, 4'h1, 0);
        row(1, 0, 0, 0, 0, 4'h1, 4'h1, 4'h0, 1);
        row(1, 0, 0, 0, 0, 4'hF, 4'hE, 4'h0, 1);

        // Pending ch3 write, then reset mid-period: back to divide-by-4, nothing pending.
        row(1, 1, 3, 9, 0, 4'hC, 4'h0, 4'h8, 0);
        row(0, 0, 3, 0, 0, 4'h0, 4'h0, 4'h0, 1);
        row(0, 0, 3, 0, 0, 4'h0, 4'h0, 4'h0, 1);
        row(1, 0, 3, 0, 0, 4'hF, 4'h0, 4'h0, 1);
        row(1, 0, 3, 0, 0, 4'h0, 4'h0, 4'h0, 1);
        row(1, 0, 3, 0, 0, 4'h0, 4'h0, 4'h0, 1);
        row(1, 0, 3, 0, 0, 4'hF, 4'hF, 4'h0, 1);
        row(1, 0, 3, 0, 0, 4'hF, 4'h0, 4'h0, 1);

        @(negedge clk);
        @(negedge clk);
        cmp("queue_drained", row_idx, 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
